// File: rtl/tick_divider_chain.sv
// Cascade of STAGES divide-by-div_cur tick counters sharing one run-time loadable divisor.
// Optional TICK_DIVIDER_ONESHOT_EN adds a oneshot input that stops the chain after the last stage wraps.
module tick_divider_chain #(
  parameter int WIDTH       = 4,
  parameter int STAGES      = 2,
  parameter int DIV_DEFAULT = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick_in,
  input  logic                      enable,
  input  logic                      div_load,
  input  logic [WIDTH-1:0]          div_value,
`ifdef TICK_DIVIDER_ONESHOT_EN
  input  logic                      oneshot,
  output logic                      done,
`endif
  output logic                      div_err,
  output logic [WIDTH-1:0]          div_cur,
  output logic [STAGES-1:0]         stage_tick,
  output logic [STAGES*WIDTH-1:0]   stage_count
);

  logic [WIDTH-1:0]  count [STAGES];
  logic [STAGES-1:0] stage_in;
  logic [STAGES-1:0] wrap;
  logic [WIDTH-1:0]  div_max;
  logic              load_ok;

  // Stage k>0 is fed by the registered pulse of stage k-1, giving one cycle of latency per stage.
  always_comb begin
    stage_in    = '0;
    wrap        = '0;
    stage_count = '0;
    div_max     = div_cur - WIDTH'(1);
    load_ok     = div_load && (div_value >= WIDTH'(2));
    stage_in[0] = tick_in;
    for (int k = 1; k < STAGES; k++) begin
      stage_in[k] = stage_tick[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      wrap[k] = stage_in[k] && (count[k] == div_max);
      stage_count[k*WIDTH +: WIDTH] = count[k];
    end
  end

  // A valid load wins over everything except reset; an invalid one only raises div_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cur    <= WIDTH'(DIV_DEFAULT);
      div_err    <= 1'b0;
      stage_tick <= '0;
      for (int k = 0; k < STAGES; k++) count[k] <= '0;
`ifdef TICK_DIVIDER_ONESHOT_EN
      done       <= 1'b0;
`endif
    end else begin
      div_err <= div_load && !load_ok;
`ifdef TICK_DIVIDER_ONESHOT_EN
      if (!oneshot) done <= 1'b0;
`endif
      if (load_ok) begin
        div_cur    <= div_value;
        stage_tick <= '0;
        for (int k = 0; k < STAGES; k++) count[k] <= '0;
`ifdef TICK_DIVIDER_ONESHOT_EN
        done       <= 1'b0;
      end else if (oneshot && (done || stage_tick[STAGES-1])) begin
        // Once the final pulse has gone out the chain parks at zero until reloaded.
        done       <= 1'b1;
        stage_tick <= '0;
        for (int k = 0; k < STAGES; k++) count[k] <= '0;
`endif
      end else if (!enable) begin
        stage_tick <= '0;
      end else begin
        for (int k = 0; k < STAGES; k++) begin
          if (wrap[k]) begin
            count[k] <= '0;
          end else if (stage_in[k]) begin
            count[k] <= count[k] + WIDTH'(1);
          end
        end
        stage_tick <= wrap;
      end
    end
  end

endmodule

// File: tb/tb_tick_divider_chain.sv
// Directed bench for tick_divider_chain with default parameters (WIDTH=4, STAGES=2, DIV=10).
module tb_tick_divider_chain;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_in;
  logic       enable;
  logic       div_load;
  logic [3:0] div_value;
  logic       div_err;
  logic [3:0] div_cur;
  logic [1:0] stage_tick;
  logic [7:0] stage_count;

  int total_checks = 0;
  int passed_checks = 0;

  typedef struct {
    logic       rst;
    logic       tin;
    logic       en;
    logic       ld;
    logic [3:0] dv;
    logic [1:0] etick;
    logic [3:0] ec0;
    logic [3:0] ec1;
    logic [3:0] ediv;
    logic       eerr;
  } vec_t;

  vec_t vecs [15];

  tick_divider_chain dut (
    .clk         (clk),
    .reset       (reset),
    .tick_in     (tick_in),
    .enable      (enable),
    .div_load    (div_load),
    .div_value   (div_value),
    .div_err     (div_err),
    .div_cur     (div_cur),
    .stage_tick  (stage_tick),
    .stage_count (stage_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_checks++;
    if (act == exp) passed_checks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic t, input logic e,
                               input logic l, input logic [3:0] v);
    reset     = r;
    tick_in   = t;
    enable    = e;
    div_load  = l;
    div_value = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int etick, input int ec0,
                             input int ec1, input int ediv, input int eerr);
    check({name, " tick"},   int'(stage_tick),       etick);
    check({name, " count0"}, int'(stage_count[3:0]), ec0);
    check({name, " count1"}, int'(stage_count[7:4]), ec1);
    check({name, " div"},    int'(div_cur),          ediv);
    check({name, " err"},    int'(div_err),          eerr);
  endtask

  initial begin
    // Invalid loads, back-to-back ticks, then a valid load of 5 arriving with a tick at count 7.
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 2'b00, 4'd1, 4'd0, 4'd10, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'b00, 4'd1, 4'd0, 4'd10, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 2'b00, 4'd2, 4'd0, 4'd10, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'b00, 4'd3, 4'd0, 4'd10, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'b00, 4'd4, 4'd0, 4'd10, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'b00, 4'd5, 4'd0, 4'd10, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'b00, 4'd6, 4'd0, 4'd10, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'b00, 4'd7, 4'd0, 4'd10, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 2'b00, 4'd0, 4'd0, 4'd5,  1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'b00, 4'd1, 4'd0, 4'd5,  1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'b00, 4'd2, 4'd0, 4'd5,  1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'b00, 4'd3, 4'd0, 4'd5,  1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'b00, 4'd4, 4'd0, 4'd5,  1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'b01, 4'd0, 4'd0, 4'd5,  1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'b00, 4'd0, 4'd1, 4'd5,  1'b0};

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("reset", 0, 0, 0, 10, 0);

    // Sparse ticks, one every 5 cycles, up to the first stage-1 wrap.
    for (int n = 1; n <= 100; n++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      checkOutput($sformatf("sparse n=%0d edge", n), (n % 10 == 0) ? 1 : 0,
                  n % 10, ((n - 1) / 10) % 10, 10, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      checkOutput($sformatf("sparse n=%0d next", n), (n == 100) ? 2 : 0,
                  n % 10, (n / 10) % 10, 10, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    end

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].tin, vecs[i].en, vecs[i].ld, vecs[i].dv);
      checkOutput($sformatf("vec%0d", i), int'(vecs[i].etick), int'(vecs[i].ec0),
                  int'(vecs[i].ec1), int'(vecs[i].ediv), int'(vecs[i].eerr));
    end

    // Freeze with stage 0 at 9 of 10: ticks during enable=0 are ignored, not queued.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd10);
    checkOutput("reload10", 0, 0, 0, 10, 0);
    for (int i = 1; i <= 9; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("at9", 0, 9, 0, 10, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput($sformatf("frozen%0d", i), 0, 9, 0, 10, 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("unfreeze", 1, 0, 0, 10, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("unfreeze+1", 0, 0, 1, 10, 0);

    // Reset mid-count with tick_in high discards progress and emits nothing.
    for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("at6", 0, 6, 1, 10, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("midreset", 0, 0, 0, 10, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("postreset", 0, 0, 0, 10, 0);

    // Divide-by-2 with tick_in held high: stage 0 every 2nd cycle, stage 1 every 4th.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd2);
    checkOutput("load2", 0, 0, 0, 2, 0);
    for (int j = 1; j <= 12; j++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      checkOutput($sformatf("div2 j=%0d", j),
                  ((j % 2 == 0) ? 1 : 0) + ((j >= 2 && (j - 1) % 4 == 0) ? 2 : 0),
                  j % 2, ((j - 1) / 2) % 2, 2, 0);
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
